countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter N, default 4, giving the counter and reload width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in  input  N  reload/preset value.
REQ-005 SHALL have port ld  input  1  load strobe for in.
REQ-006 SHALL have port start  input  1  start-countdown request.
REQ-007 SHALL have port clr  input  1  synchronous abort/clear.
REQ-008 SHALL have port cnten  input  1  decrement enable (tick).
REQ-009 SHALL have port auto_rld  input  1  reload and restart on expiry when high.
REQ-010 SHALL have port out  output  N  current count, registered.
REQ-011 SHALL have port zero  output  1  high when out == 0 (combinational from out).
REQ-012 SHALL have port busy  output  1  high in RUN state.
REQ-013 SHALL have port done  output  1  expiry pulse, high only in DONE state.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; one state per clock.
REQ-015 SHALL hold reload register rld; any edge with ld=1 and clr=0 SHALL set rld <= in, in every state.
REQ-016 In IDLE, ld=1 SHALL also set out <= in; in RUN or DONE, ld SHALL NOT change out.
REQ-017 In IDLE, start=1 with out != 0 SHALL go to RUN; with out == 0 SHALL go to DONE; out unchanged on that edge.
REQ-018 In IDLE, ld and start in the same cycle SHALL use the new value: out <= in; next state RUN if in != 0, else DONE.
REQ-019 In RUN, cnten=1 SHALL set out <= out - 1; cnten=0 SHALL hold out.
REQ-020 In RUN, cnten=1 with out == 1 SHALL set out <= 0 and go to DONE; no decrement below 0, no wrap-around.
REQ-021 DONE SHALL last exactly one cycle (done high for exactly one cycle); cnten ignored in DONE.
REQ-022 Leaving DONE with auto_rld=0 SHALL go to IDLE, out held at 0.
REQ-023 Leaving DONE with auto_rld=1 SHALL set out <= rld and go to RUN if rld != 0; if rld == 0, go to IDLE.
REQ-024 start SHALL be ignored in RUN and DONE.
REQ-025 clr=1 SHALL take priority over all other inputs: out <= 0, state IDLE, done low next cycle; rld unchanged.
REQ-026 Latency: with out=K>0 and cnten held high from the start edge, done SHALL be high in the cycle after the K-th edge following the start edge.

Reset
REQ-027 rst_n low SHALL asynchronously force out=0, rld=0, state IDLE, busy=0, done=0; zero=1.
REQ-028 Reset asserted mid-countdown SHALL abort with no done pulse; after release the block SHALL wait in IDLE for start.

Structure
REQ-029 State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared package timer_pkg, with the default width constant.
REQ-030 The datapath SHALL be a sub-module down_counter (parameter N; ports clk, rst_n, in, ld, clr, dec, out, zero) instantiated under the FSM.
REQ-031 All outputs except zero SHALL be registered or decoded from registered state only.

Verification
REQ-032 Basic: N=4, ld in=3 in IDLE, start, cnten=1 held -> out 3,2,1,0 on successive edges; busy high 3 cycles; done high 1 cycle; then IDLE.
REQ-033 Gated ticks: in=2, start, cnten toggling 1,0,1 -> out 2,1,1,0; done only after the second enabled tick.
REQ-034 Auto-reload: in=2, auto_rld=1, cnten=1 -> done pulses every 3 cycles, out 2,1,0,2,1,0; mid-run ld in=5 -> next reload loads 5, current count unaffected.
REQ-035 Zero start: out=0, start -> DONE next cycle, done one pulse, busy never high.
REQ-036 Abort: clr during RUN at out=6 (in=9) -> out=0, IDLE, no done; rld still 9 (verify with ld=0 then auto_rld restart path).
REQ-037 Async reset: drop rst_n between clock edges while out=7 in RUN -> out=0, busy=0 immediately, no done after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default width.
package timer_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with synchronous clear; never decrements below zero.
module down_counter
    import timer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         ld,
    input  logic         clr,
    input  logic         dec,
    output logic [N-1:0] out,
    output logic         zero
);

    logic [N-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (ld) begin
            count_reg <= in;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - N'(1);
        end
    end

    assign out  = count_reg;
    assign zero = (count_reg == '0);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: IDLE/RUN/DONE controller with a reload register, driving a down_counter.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         ld,
    input  logic         start,
    input  logic         clr,
    input  logic         cnten,
    input  logic         auto_rld,
    output logic [N-1:0] out,
    output logic         zero,
    output logic         busy,
    output logic         done
);

    state_t       state_reg;
    state_t       state_next;
    logic [N-1:0] rld_reg;
    logic [N-1:0] cnt_out;
    logic         cnt_zero;
    logic         cnt_ld;
    logic [N-1:0] cnt_val;
    logic         cnt_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The reload value follows ld in every state; clr leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rld_reg <= '0;
        end else if (ld && !clr) begin
            rld_reg <= in;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // A same-cycle load decides RUN vs DONE from the new value.
                if (start) begin
                    state_next = (((ld ? in : cnt_out)) != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (cnten && (cnt_out == N'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = (auto_rld && (rld_reg != '0)) ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (clr) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy    = (state_reg == RUN);
        done    = (state_reg == DONE);
        cnt_ld  = 1'b0;
        cnt_val = in;
        cnt_dec = 1'b0;
        case (state_reg)
            IDLE: cnt_ld = ld;
            RUN:  cnt_dec = cnten;
            DONE: begin
                if (auto_rld && (rld_reg != '0)) begin
                    cnt_ld  = 1'b1;
                    cnt_val = rld_reg;
                end
            end
            default: ;
        endcase
    end

    down_counter #(.N(N)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (cnt_val),
        .ld    (cnt_ld),
        .clr   (clr),
        .dec   (cnt_dec),
        .out   (cnt_out),
        .zero  (cnt_zero)
    );

    assign out  = cnt_out;
    assign zero = cnt_zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios followed by randomized traffic.
module tb_countdown_timer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in;
    logic         ld, start, clr, cnten, auto_rld;
    logic [N-1:0] out;
    logic         zero, busy, done;
    bit           probe = 1'b0;

    always #5 clk = ~clk;

    countdown_timer #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .ld       (ld),
        .start    (start),
        .clr      (clr),
        .cnten    (cnten),
        .auto_rld (auto_rld),
        .out      (out),
        .zero     (zero),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic [N-1:0] out;
        logic         busy;
        logic         done;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural reference: a count, a reload value, and two flags saying
    // whether a countdown is in progress or has just expired.
    int m_out, m_rld;
    bit m_running, m_expired;

    task automatic model_reset();
        m_out = 0; m_rld = 0; m_running = 0; m_expired = 0;
    endtask

    task automatic drive(input bit l, input int v, input bit s, input bit c,
                         input bit en, input bit ar);
        int   nv;
        exp_t e;
        ld = l; in = v[N-1:0]; start = s; clr = c; cnten = en; auto_rld = ar;
        if (c) begin
            m_out = 0; m_running = 0; m_expired = 0;
        end else if (m_expired) begin
            m_expired = 0;
            if (ar && m_rld != 0) begin
                m_out = m_rld; m_running = 1;
            end
        end else if (m_running) begin
            if (en) begin
                m_out = m_out - 1;
                if (m_out == 0) begin
                    m_running = 0; m_expired = 1;
                end
            end
        end else begin
            nv = l ? v : m_out;
            m_out = nv;
            if (s) begin
                if (nv != 0) m_running = 1;
                else         m_expired = 1;
            end
        end
        if (l && !c) m_rld = v;
        e.out  = m_out[N-1:0];
        e.busy = m_running;
        e.done = m_expired;
        e.zero = (m_out == 0);
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        ld = 0; start = 0; clr = 0; cnten = 0; auto_rld = 0; in = '0;
        model_reset();
        #1 probe = ~probe;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: during reset the outputs must sit at their reset values;
    // otherwise each negedge compares against the oldest queued expectation.
    always @(negedge clk or probe) begin
        exp_t e;
        exp_t a;
        a = {out, busy, done, zero};
        if (!rst_n) begin
            sb.delete();
            e = '0;
            e.zero = 1'b1;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset_state t=%0t: got out=%0d busy=%b done=%b zero=%b, expected out=0 busy=0 done=0 zero=1",
                         $time, out, busy, done, zero);
            end
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_check t=%0t: got out=%0d busy=%b done=%b zero=%b, expected out=%0d busy=%b done=%b zero=%b",
                         $time, out, busy, done, zero, e.out, e.busy, e.done, e.zero);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ld = 0; start = 0; clr = 0; cnten = 0; auto_rld = 0; in = '0;
        model_reset();
        #2 probe = ~probe;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic countdown from 3
        drive(1, 3, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0);

        // Gated ticks from 2
        drive(1, 2, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);

        // Auto-reload with a mid-run reload change to 5
        drive(1, 2, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 1);
        drive(1, 5, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 0);

        // Zero start
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);

        // Abort at 6, then prove rld survived via zero-start + auto reload
        drive(1, 9, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 0);

        // Asynchronous reset while counting at 7
        drive(1, 7, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        async_reset();
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 1);

        // Randomized traffic
        begin
            bit ar;
            ar = 0;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 19) == 0) ar = ~ar;
                if ($urandom_range(0, 399) == 0) begin
                    async_reset();
                end else begin
                    drive($urandom_range(0, 7) == 0, $urandom_range(0, 15),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                          $urandom_range(0, 1) == 1, ar);
                end
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
